// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the HS receive decoder (usb_rx_decoder).
package usb_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_DATA  = 2'd1,
        ST_DRAIN = 2'd2
    } rx_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_STUFF    = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_EMPTY    = 2'd3
    } rx_err_e;

    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    localparam logic        NRZI_IDLE_LEVEL = 1'b1;
    localparam int unsigned STUFF_RUN_LEN   = 6;

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 LFSR (LSB-first data, MSB-side feedback) with clear and bit-enable.
module usb_crc16
    import usb_rx_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;
    logic        w_fb;

    assign w_fb  = r_crc[15] ^ i_bit;
    assign o_crc = r_crc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_crc <= CRC16_INIT;
        end else if (i_clear) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_rx_decoder.sv
// HS receive decoder: NRZI decode, SYNC hunt, unstuffing, LSB-first byte assembly, EOP/error detection.
// Optional CRC16 check of the post-PID bytes is enabled by defining USB_RX_CRC16_EN.
module usb_rx_decoder
    import usb_rx_pkg::*;
#(
    parameter int unsigned SYNC_MIN_ZEROS = 12,
    parameter int unsigned MAX_PKT_BYTES  = 1027
)(
    input  logic       clock_480,
    input  logic       reset_n,
    input  logic       data_in,
    input  logic       data_valid,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error,
    output logic [1:0] rx_err_code
`ifdef USB_RX_CRC16_EN
    ,
    output logic       crc_ok
`endif
);

    localparam int unsigned ZW = $clog2(SYNC_MIN_ZEROS + 1);
    localparam int unsigned BW = $clog2(MAX_PKT_BYTES + 1);

    rx_state_e     r_state;
    logic          r_prev_level;
    logic [ZW-1:0] r_zero_cnt;
    logic [2:0]    r_ones_cnt;
    logic [2:0]    r_bit_cnt;
    logic [BW-1:0] r_byte_cnt;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_byte;
    logic          r_rx_byte_valid;
    logic          r_rx_active;
    logic          r_rx_eop;
    logic          r_rx_error;
    rx_err_e       r_rx_err_code;

    logic          w_bit;
    logic          w_sync_done;
    logic          w_stuff_slot;
    logic          w_byte_done;
    logic [7:0]    w_byte_next;

    assign w_bit        = ~(data_in ^ r_prev_level);
    assign w_sync_done  = (r_state == ST_HUNT) && w_bit && (r_zero_cnt >= ZW'(SYNC_MIN_ZEROS));
    assign w_stuff_slot = (r_ones_cnt == 3'(STUFF_RUN_LEN));
    assign w_byte_done  = (r_bit_cnt == 3'd7);
    assign w_byte_next  = {w_bit, r_shift[7:1]};

    assign rx_byte       = r_rx_byte;
    assign rx_byte_valid = r_rx_byte_valid;
    assign rx_active     = r_rx_active;
    assign rx_eop        = r_rx_eop;
    assign rx_error      = r_rx_error;
    assign rx_err_code   = r_rx_err_code;

    // Receive FSM; every counter advances only on qualified bits
    always_ff @(posedge clock_480) begin
        if (!reset_n) begin
            r_state         <= ST_HUNT;
            r_prev_level    <= NRZI_IDLE_LEVEL;
            r_zero_cnt      <= '0;
            r_ones_cnt      <= '0;
            r_bit_cnt       <= '0;
            r_byte_cnt      <= '0;
            r_shift         <= '0;
            r_rx_byte       <= '0;
            r_rx_byte_valid <= 1'b0;
            r_rx_active     <= 1'b0;
            r_rx_eop        <= 1'b0;
            r_rx_error      <= 1'b0;
            r_rx_err_code   <= ERR_NONE;
        end else begin
            r_rx_byte_valid <= 1'b0;
            r_rx_eop        <= 1'b0;
            r_rx_error      <= 1'b0;
            // rx_active covers the terminating strobe cycle, then drops
            if (r_rx_eop || r_rx_error) begin
                r_rx_active <= 1'b0;
            end
            if (data_valid) begin
                r_prev_level <= data_in;
                unique case (r_state)
                    ST_HUNT: begin
                        if (w_sync_done) begin
                            r_state     <= ST_DATA;
                            r_zero_cnt  <= '0;
                            r_ones_cnt  <= '0;
                            r_bit_cnt   <= '0;
                            r_byte_cnt  <= '0;
                            r_rx_active <= 1'b1;
                        end else if (!w_bit) begin
                            if (r_zero_cnt < ZW'(SYNC_MIN_ZEROS)) begin
                                r_zero_cnt <= r_zero_cnt + ZW'(1);
                            end
                        end else begin
                            r_zero_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (w_stuff_slot) begin
                            r_ones_cnt <= '0;
                            if (w_bit) begin
                                r_state <= ST_HUNT;
                                if (r_byte_cnt != '0) begin
                                    r_rx_eop <= 1'b1;
                                end else begin
                                    r_rx_error    <= 1'b1;
                                    r_rx_err_code <= ERR_EMPTY;
                                end
                            end
                        end else begin
                            r_ones_cnt <= w_bit ? (r_ones_cnt + 3'd1) : 3'd0;
                            r_shift    <= w_byte_next;
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (w_byte_done) begin
                                if (r_byte_cnt == BW'(MAX_PKT_BYTES)) begin
                                    r_state       <= ST_DRAIN;
                                    r_rx_error    <= 1'b1;
                                    r_rx_err_code <= ERR_OVERFLOW;
                                end else begin
                                    r_rx_byte       <= w_byte_next;
                                    r_rx_byte_valid <= 1'b1;
                                    r_byte_cnt      <= r_byte_cnt + BW'(1);
                                end
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (!w_bit) begin
                            r_ones_cnt <= '0;
                        end else if (w_stuff_slot) begin
                            r_ones_cnt <= '0;
                            r_state    <= ST_HUNT;
                        end else begin
                            r_ones_cnt <= r_ones_cnt + 3'd1;
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

`ifdef USB_RX_CRC16_EN
    logic [15:0] w_crc;
    logic [15:0] w_crc_res;
    logic        w_crc_en;
    logic        w_eop_hit;
    logic [15:0] r_crc_snap;
    logic        r_snap_pend;
    logic        r_crc_ok;

    assign w_crc_en  = data_valid && (r_state == ST_DATA) && !w_stuff_slot && (r_byte_cnt != '0);
    assign w_eop_hit = data_valid && (r_state == ST_DATA) && w_stuff_slot && w_bit && (r_byte_cnt != '0);
    // Residual must exclude the discarded EOP bits, so compare against the last byte-aligned value
    assign w_crc_res = r_snap_pend ? w_crc : r_crc_snap;
    assign crc_ok    = r_crc_ok;

    usb_crc16 u_crc16 (
        .i_clk   (clock_480),
        .i_rst_n (reset_n),
        .i_clear (data_valid && w_sync_done),
        .i_en    (w_crc_en),
        .i_bit   (w_bit),
        .o_crc   (w_crc)
    );

    always_ff @(posedge clock_480) begin
        if (!reset_n) begin
            r_crc_snap  <= CRC16_INIT;
            r_snap_pend <= 1'b0;
            r_crc_ok    <= 1'b0;
        end else begin
            r_crc_ok    <= 1'b0;
            r_snap_pend <= w_crc_en && w_byte_done;
            if (r_snap_pend) begin
                r_crc_snap <= w_crc;
            end
            if (data_valid && w_sync_done) begin
                r_crc_snap <= CRC16_INIT;
            end
            if (w_eop_hit) begin
                r_crc_ok <= (w_crc_res == CRC16_RESIDUAL) && (r_byte_cnt >= BW'(3));
            end
        end
    end
`endif

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder; the CRC section is built only when USB_RX_CRC16_EN is defined.
module tb_usb_rx_decoder;

    logic       clock_480 = 1'b0;
    logic       reset_n   = 1'b0;
    logic       data_in   = 1'b1;
    logic       data_valid = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_active;
    logic       rx_eop;
    logic       rx_error;
    logic [1:0] rx_err_code;
`ifdef USB_RX_CRC16_EN
    logic       crc_ok;
`endif

    usb_rx_decoder dut (
        .clock_480     (clock_480),
        .reset_n       (reset_n),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_active     (rx_active),
        .rx_eop        (rx_eop),
        .rx_error      (rx_error),
        .rx_err_code   (rx_err_code)
`ifdef USB_RX_CRC16_EN
        ,
        .crc_ok        (crc_ok)
`endif
    );

    always #5 clock_480 = ~clock_480;

    int         n_chk = 0;
    int         n_err = 0;
    logic       line  = 1'b1;
    int         ones  = 0;
    logic [7:0] byte_q[$];
    int         eop_cnt  = 0;
    int         err_cnt  = 0;
    int         both_cnt = 0;

    // Strobe recorder, sampled away from the active edge
    always @(negedge clock_480) begin
        if (rx_byte_valid) byte_q.push_back(rx_byte);
        if (rx_eop) eop_cnt++;
        if (rx_error) err_cnt++;
        if (rx_eop && rx_error) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic lv, input logic v);
        data_in    = lv;
        data_valid = v;
        @(posedge clock_480);
        #1;
    endtask

    task automatic nrzi(input logic b);
        if (!b) line = ~line;
        tick(line, 1'b1);
    endtask

    task automatic data_bit(input logic b);
        nrzi(b);
        if (b) begin
            ones++;
            if (ones == 6) begin
                nrzi(1'b0);
                ones = 0;
            end
        end else begin
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) data_bit(v[i]);
    endtask

    task automatic sync(input int nz);
        for (int i = 0; i < nz; i++) nrzi(1'b0);
        nrzi(1'b1);
        ones = 0;
    endtask

    task automatic eop();
        nrzi(1'b0);
        repeat (7) nrzi(1'b1);
        ones = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) nrzi(1'b1);
    endtask

    task automatic gap();
        tick(~line, 1'b0);
    endtask

    task automatic clear_mon();
        byte_q.delete();
        eop_cnt = 0;
        err_cnt = 0;
    endtask

    function automatic logic [15:0] crc16_2(input logic [7:0] b0, input logic [7:0] b1);
        logic [15:0] c;
        logic [15:0] d;
        logic        fb;
        c = 16'hFFFF;
        d = {b1, b0};
        for (int i = 0; i < 16; i++) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    initial begin
        // reset state
        repeat (3) tick(1'b1, 1'b0);
        chk("rst_active", 32'(rx_active), 32'd0);
        chk("rst_byte", 32'(rx_byte), 32'h0);
        chk("rst_valid", 32'(rx_byte_valid), 32'd0);
        chk("rst_code", 32'(rx_err_code), 32'd0);
        reset_n = 1'b1;

        // basic packet with a data_valid gap
        idle(5);
        clear_mon();
        sync(20);
        chk("t1_active_rise", 32'(rx_active), 32'd1);
        send_byte(8'hC3);
        gap();
        gap();
        send_byte(8'h5A);
        eop();
        chk("t1_eop_strobe", 32'(rx_eop), 32'd1);
        chk("t1_active_at_eop", 32'(rx_active), 32'd1);
        idle(1);
        chk("t1_active_fall", 32'(rx_active), 32'd0);
        chk("t1_nbytes", 32'(byte_q.size()), 32'd2);
        chk("t1_byte0", 32'(byte_q[0]), 32'hC3);
        chk("t1_byte1", 32'(byte_q[1]), 32'h5A);
        chk("t1_eops", 32'(eop_cnt), 32'd1);
        chk("t1_errs", 32'(err_cnt), 32'd0);

        // short SYNC (8 and 11 zeros) is never accepted
        idle(3);
        clear_mon();
        sync(8);
        send_byte(8'hC3);
        eop();
        idle(20);
        sync(11);
        send_byte(8'h5A);
        eop();
        idle(3);
        chk("t2_nbytes", 32'(byte_q.size()), 32'd0);
        chk("t2_eops", 32'(eop_cnt), 32'd0);
        chk("t2_errs", 32'(err_cnt), 32'd0);
        chk("t2_active", 32'(rx_active), 32'd0);

        // stuffed bits are dropped
        idle(3);
        clear_mon();
        sync(15);
        send_byte(8'h3F);
        send_byte(8'hFF);
        eop();
        idle(2);
        chk("t3_nbytes", 32'(byte_q.size()), 32'd2);
        chk("t3_byte0", 32'(byte_q[0]), 32'h3F);
        chk("t3_byte1", 32'(byte_q[1]), 32'hFF);
        chk("t3_eops", 32'(eop_cnt), 32'd1);
        chk("t3_errs", 32'(err_cnt), 32'd0);

        // overflow at 1028 bytes, minimum-length SYNC
        idle(3);
        clear_mon();
        sync(12);
        for (int i = 0; i < 1028; i++) send_byte(8'(i));
        chk("t4_err_strobe", 32'(rx_error), 32'd1);
        chk("t4_err_code", 32'(rx_err_code), 32'd2);
        nrzi(1'b0);
        chk("t4_drain_inactive", 32'(rx_active), 32'd0);
        repeat (7) nrzi(1'b1);
        ones = 0;
        idle(3);
        chk("t4_nbytes", 32'(byte_q.size()), 32'd1027);
        chk("t4_first", 32'(byte_q[0]), 32'h00);
        chk("t4_last", 32'(byte_q[1026]), 32'h02);
        chk("t4_eops", 32'(eop_cnt), 32'd0);
        chk("t4_errs", 32'(err_cnt), 32'd1);
        chk("t4_active_after", 32'(rx_active), 32'd0);

        // empty packet
        idle(3);
        clear_mon();
        sync(20);
        eop();
        chk("t5_err_strobe", 32'(rx_error), 32'd1);
        chk("t5_err_code", 32'(rx_err_code), 32'd3);
        chk("t5_no_eop", 32'(rx_eop), 32'd0);
        idle(2);
        chk("t5_code_held", 32'(rx_err_code), 32'd3);
        chk("t5_errs", 32'(err_cnt), 32'd1);
        chk("t5_eops", 32'(eop_cnt), 32'd0);

        // reset mid-byte, then a clean packet
        idle(3);
        sync(20);
        send_byte(8'hC3);
        data_bit(1'b1);
        data_bit(1'b0);
        data_bit(1'b1);
        chk("t6_pre_byte", 32'(rx_byte), 32'hC3);
        chk("t6_pre_active", 32'(rx_active), 32'd1);
        reset_n = 1'b0;
        tick(1'b1, 1'b1);
        chk("t6_rst_active", 32'(rx_active), 32'd0);
        chk("t6_rst_byte", 32'(rx_byte), 32'h0);
        chk("t6_rst_code", 32'(rx_err_code), 32'd0);
        chk("t6_rst_strobes", 32'({rx_byte_valid, rx_eop, rx_error}), 32'd0);
        reset_n = 1'b1;
        line = 1'b1;
        ones = 0;
        idle(3);
        clear_mon();
        sync(20);
        send_byte(8'hA5);
        eop();
        idle(2);
        chk("t6_nbytes", 32'(byte_q.size()), 32'd1);
        chk("t6_byte0", 32'(byte_q[0]), 32'hA5);
        chk("t6_eops", 32'(eop_cnt), 32'd1);
        chk("t6_errs", 32'(err_cnt), 32'd0);

`ifdef USB_RX_CRC16_EN
        begin
            logic [15:0] crc;
            crc = crc16_2(8'h00, 8'h01);
            idle(3);
            sync(20);
            send_byte(8'hC3);
            send_byte(8'h00);
            send_byte(8'h01);
            for (int i = 15; i >= 0; i--) data_bit(~crc[i]);
            eop();
            chk("crc_good_eop", 32'(rx_eop), 32'd1);
            chk("crc_good_ok", 32'(crc_ok), 32'd1);
            idle(3);
            sync(20);
            send_byte(8'hC3);
            send_byte(8'h00);
            send_byte(8'h03);
            for (int i = 15; i >= 0; i--) data_bit(~crc[i]);
            eop();
            chk("crc_bad_eop", 32'(rx_eop), 32'd1);
            chk("crc_bad_ok", 32'(crc_ok), 32'd0);
            idle(2);
        end
`endif

        chk("mutex_eop_err", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
